// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit of the multi-cycle NPC core.
//
// Owns the architectural PC and fetches one instruction per executed
// instruction. It issues a single read to instruction memory, presents the
// word and its PC to decode, then waits for execute to supply the next PC.
// A flush redirects the PC at any time after boot. If a read is still
// outstanding at that point, its response is discarded in DROP.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   imem_req_valid/ready read request handshake, imem_req_addr = pc
//   imem_rsp_valid/data  read response (single-cycle pulse), imem_rsp_err fault
//   instr_valid/ready    handoff to decode of instr, pc, fetch_err
//   fetch_err            0 none, 1 access fault, 2 misaligned PC
//   npc_valid, npc       next PC from execute (complete, no +4 here)
//   flush_valid/pc       redirect, highest priority
// ---------------------------------------------------------------------------
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [1:0]  fetch_err,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc
);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_EXEC = 3'd4,
        S_DROP = 3'd5
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0]  ERR_NONE  = 2'd0;
    localparam logic [1:0]  ERR_FAULT = 2'd1;
    localparam logic [1:0]  ERR_ALIGN = 2'd2;

    // A fetch target is unusable when it is not word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    state_e      state_q, state_d, state_c;
    logic [31:0] pc_q, pc_d, pc_c;
    logic [31:0] instr_q, instr_d, instr_c;
    logic [1:0]  ferr_q, ferr_d, ferr_c;
    logic        req_valid_q, req_valid_d;
    logic        instr_valid_q, instr_valid_d;
    logic        go_fetch_s;
    logic [31:0] fetch_pc_s;

    // Next-state decode; go_fetch_s routes every "start a fetch at X" path
    // through one place so the misaligned-target check is applied uniformly.
    always_comb begin
        state_c    = state_q;
        pc_c       = pc_q;
        instr_c    = instr_q;
        ferr_c     = ferr_q;
        go_fetch_s = 1'b0;
        fetch_pc_s = pc_q;
        case (state_q)
            S_BOOT: begin
                go_fetch_s = 1'b1;
                fetch_pc_s = pc_q;
            end
            S_REQ: begin
                if (flush_valid) begin
                    if (imem_req_ready) begin
                        // Request leaves this cycle: its response must be dropped.
                        state_c = S_DROP;
                        pc_c    = flush_pc;
                    end else begin
                        go_fetch_s = 1'b1;
                        fetch_pc_s = flush_pc;
                    end
                end else if (imem_req_ready) begin
                    state_c = S_WAIT;
                end else begin
                    state_c = S_REQ;
                end
            end
            S_WAIT: begin
                if (flush_valid) begin
                    if (imem_rsp_valid) begin
                        go_fetch_s = 1'b1;
                        fetch_pc_s = flush_pc;
                    end else begin
                        state_c = S_DROP;
                        pc_c    = flush_pc;
                    end
                end else if (imem_rsp_valid) begin
                    state_c = S_HOLD;
                    instr_c = imem_rsp_data;
                    ferr_c  = imem_rsp_err ? ERR_FAULT : ERR_NONE;
                end else begin
                    state_c = S_WAIT;
                end
            end
            S_HOLD: begin
                // A handoff coinciding with a flush is void; decode drops it.
                if (flush_valid) begin
                    go_fetch_s = 1'b1;
                    fetch_pc_s = flush_pc;
                end else if (instr_ready) begin
                    state_c = S_EXEC;
                end else begin
                    state_c = S_HOLD;
                end
            end
            S_EXEC: begin
                if (flush_valid) begin
                    go_fetch_s = 1'b1;
                    fetch_pc_s = flush_pc;
                end else if (npc_valid) begin
                    go_fetch_s = 1'b1;
                    fetch_pc_s = npc;
                end else begin
                    state_c = S_EXEC;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    go_fetch_s = 1'b1;
                    fetch_pc_s = flush_valid ? flush_pc : pc_q;
                end else if (flush_valid) begin
                    pc_c = flush_pc;
                end else begin
                    state_c = S_DROP;
                end
            end
            default: begin
                state_c = S_BOOT;
                pc_c    = RESET_PC;
            end
        endcase
    end

    // Resolve a fetch start: aligned targets request memory, misaligned ones
    // present a NOP with the alignment error straight away.
    always_comb begin
        state_d = state_c;
        pc_d    = pc_c;
        instr_d = instr_c;
        ferr_d  = ferr_c;
        if (go_fetch_s) begin
            pc_d = fetch_pc_s;
            if (is_misaligned(fetch_pc_s)) begin
                state_d = S_HOLD;
                instr_d = NOP_INSTR;
                ferr_d  = ERR_ALIGN;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            state_d = state_c;
        end
    end

    // Output valids are registered from the next state, not decoded from inputs.
    always_comb begin
        req_valid_d   = (state_d == S_REQ);
        instr_valid_d = (state_d == S_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            ferr_q        <= ERR_NONE;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            ferr_q        <= ferr_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign pc             = pc_q;
    assign fetch_err      = ferr_q;

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, pc;
    logic [1:0]  fetch_err;
    logic        npc_valid;
    logic [31:0] npc;
    logic        flush_valid;
    logic [31:0] flush_pc;

    always #5 clk = ~clk;

    ifu dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc(pc), .fetch_err(fetch_err),
        .npc_valid(npc_valid), .npc(npc),
        .flush_valid(flush_valid), .flush_pc(flush_pc)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        imem_rsp_err = 1'b0; instr_ready = 1'b0; npc_valid = 1'b0; npc = 32'h0;
        flush_valid = 1'b0; flush_pc = 32'h0;
    endtask

    // One cycle of inputs and the outputs expected after the following edge.
    typedef struct {
        logic        rdy, rv;
        logic [31:0] rd;
        logic        re, ir, nv;
        logic [31:0] np;
        logic        fl;
        logic [31:0] fp;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr, e_pc;
        logic [1:0]  e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic rdy, input logic rv, input logic [31:0] rd, input logic re,
                        input logic ir, input logic nv, input logic [31:0] np,
                        input logic fl, input logic [31:0] fp,
                        input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                        input logic [31:0] e_instr, input logic [31:0] e_pc, input logic [1:0] e_err);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.re = re; v.ir = ir; v.nv = nv; v.np = np;
        v.fl = fl; v.fp = fp; v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_err = e_err;
        tbl.push_back(v);
    endtask

    // Reference model: abstract fetch bookkeeping (what is wanted, what is in
    // flight, whether it is stale, what decode is shown, whether npc is awaited).
    logic        m_boot, m_want, m_out, m_stale, m_show, m_await;
    logic [31:0] m_pc, m_instr;
    logic [1:0]  m_err;

    task automatic m_reset();
        m_boot = 1'b1; m_want = 1'b0; m_out = 1'b0; m_stale = 1'b0;
        m_show = 1'b0; m_await = 1'b0; m_pc = RPC; m_instr = 32'h0; m_err = 2'd0;
    endtask

    task automatic m_fetch(input logic [31:0] t);
        m_pc = t; m_await = 1'b0;
        if (t % 4 != 0) begin
            m_show = 1'b1; m_want = 1'b0; m_instr = 32'h0000_0013; m_err = 2'd2;
        end else begin
            m_show = 1'b0; m_want = 1'b1;
        end
    endtask

    task automatic m_step();
        if (m_boot) begin
            m_boot = 1'b0;
            m_fetch(m_pc);
        end else if (flush_valid) begin
            m_show = 1'b0; m_await = 1'b0;
            if (m_want && imem_req_ready) begin
                m_want = 1'b0; m_out = 1'b1; m_stale = 1'b1; m_pc = flush_pc;
            end else if (m_out && !imem_rsp_valid) begin
                m_stale = 1'b1; m_want = 1'b0; m_pc = flush_pc;
            end else begin
                if (m_out) m_out = 1'b0;
                m_fetch(flush_pc);
            end
        end else if (m_want && imem_req_ready) begin
            m_want = 1'b0; m_out = 1'b1; m_stale = 1'b0;
        end else if (m_out && imem_rsp_valid) begin
            m_out = 1'b0;
            if (m_stale) m_fetch(m_pc);
            else begin
                m_show = 1'b1; m_instr = imem_rsp_data; m_err = imem_rsp_err ? 2'd1 : 2'd0;
            end
        end else if (m_show && instr_ready) begin
            m_show = 1'b0; m_await = 1'b1;
        end else if (m_await && npc_valid) begin
            m_fetch(npc);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) != 0) r[1:0] = 2'b00;
        return r;
    endfunction

    logic mem_busy;
    int   mem_cnt;

    initial begin
        rst = 1'b0;
        idle();

        addv(1,0,32'h0,0,0,0,32'h0,0,32'h0,              1,RPC,0,32'h0,32'h0,2'd0);
        addv(1,0,32'h0,0,0,0,32'h0,0,32'h0,              0,RPC,0,32'h0,32'h0,2'd0);
        addv(0,1,32'h0000_0297,0,0,0,32'h0,0,32'h0,      0,RPC,1,32'h0000_0297,RPC,2'd0);
        addv(0,0,32'h0,0,1,0,32'h0,0,32'h0,              0,RPC,0,32'h0,32'h0,2'd0);
        addv(0,0,32'h0,0,0,1,32'h8000_0004,0,32'h0,      1,32'h8000_0004,0,32'h0,32'h0,2'd0);
        for (int i = 0; i < 3; i++)
            addv(0,0,32'h0,0,0,0,32'h0,0,32'h0,          1,32'h8000_0004,0,32'h0,32'h0,2'd0);
        addv(1,0,32'h0,0,0,0,32'h0,0,32'h0,              0,32'h8000_0004,0,32'h0,32'h0,2'd0);
        addv(0,0,32'h0,0,0,0,32'h0,1,32'h8000_0100,      0,32'h8000_0100,0,32'h0,32'h0,2'd0);
        addv(0,0,32'h0,0,0,0,32'h0,0,32'h0,              0,32'h8000_0100,0,32'h0,32'h0,2'd0);
        addv(0,1,32'hDEAD_BEEF,0,0,0,32'h0,0,32'h0,      1,32'h8000_0100,0,32'h0,32'h0,2'd0);
        addv(1,0,32'h0,0,0,0,32'h0,0,32'h0,              0,32'h8000_0100,0,32'h0,32'h0,2'd0);
        addv(0,1,32'h0010_0093,1,0,0,32'h0,0,32'h0,      0,32'h8000_0100,1,32'h0010_0093,32'h8000_0100,2'd1);
        addv(0,0,32'h0,0,1,0,32'h0,0,32'h0,              0,32'h8000_0100,0,32'h0,32'h0,2'd0);
        addv(0,0,32'h0,0,0,1,32'h8000_0104,0,32'h0,      1,32'h8000_0104,0,32'h0,32'h0,2'd0);
        addv(1,0,32'h0,0,0,0,32'h0,0,32'h0,              0,32'h8000_0104,0,32'h0,32'h0,2'd0);
        addv(0,1,32'h0000_0013,0,0,0,32'h0,0,32'h0,      0,32'h8000_0104,1,32'h0000_0013,32'h8000_0104,2'd0);
        addv(0,0,32'h0,0,1,0,32'h0,0,32'h0,              0,32'h8000_0104,0,32'h0,32'h0,2'd0);
        addv(0,0,32'h0,0,0,1,32'h8000_0002,0,32'h0,      0,32'h8000_0002,1,32'h0000_0013,32'h8000_0002,2'd2);
        addv(0,0,32'h0,0,1,0,32'h0,1,32'h8000_0200,      1,32'h8000_0200,0,32'h0,32'h0,2'd0);
        addv(0,0,32'h0,0,0,1,32'h8000_0300,0,32'h0,      1,32'h8000_0200,0,32'h0,32'h0,2'd0);
        addv(1,0,32'h0,0,0,0,32'h0,0,32'h0,              0,32'h8000_0200,0,32'h0,32'h0,2'd0);
        addv(0,1,32'h1111_1111,0,0,0,32'h0,0,32'h0,      0,32'h8000_0200,1,32'h1111_1111,32'h8000_0200,2'd0);
        addv(0,0,32'h0,0,1,0,32'h0,0,32'h0,              0,32'h8000_0200,0,32'h0,32'h0,2'd0);
        addv(0,0,32'h0,0,0,1,32'h8000_0204,0,32'h0,      1,32'h8000_0204,0,32'h0,32'h0,2'd0);
        addv(1,0,32'h0,0,0,0,32'h0,0,32'h0,              0,32'h8000_0204,0,32'h0,32'h0,2'd0);
        addv(0,1,32'h2222_2222,0,0,0,32'h0,1,32'h8000_0400, 1,32'h8000_0400,0,32'h0,32'h0,2'd0);
        addv(1,0,32'h0,0,0,0,32'h0,1,32'h8000_0500,      0,32'h8000_0500,0,32'h0,32'h0,2'd0);
        addv(0,1,32'h3333_3333,0,0,0,32'h0,0,32'h0,      1,32'h8000_0500,0,32'h0,32'h0,2'd0);
        addv(0,1,32'h4444_4444,0,0,0,32'h0,0,32'h0,      1,32'h8000_0500,0,32'h0,32'h0,2'd0);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_addr", imem_req_addr, RPC);
        chk("rst_pc", pc, RPC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_fetch_err", fetch_err, 2'd0);

        // Directed table.
        rst = 1'b1;
        foreach (tbl[i]) begin
            imem_req_ready = tbl[i].rdy; imem_rsp_valid = tbl[i].rv; imem_rsp_data = tbl[i].rd;
            imem_rsp_err = tbl[i].re; instr_ready = tbl[i].ir; npc_valid = tbl[i].nv;
            npc = tbl[i].np; flush_valid = tbl[i].fl; flush_pc = tbl[i].fp;
            @(negedge clk);
            chk($sformatf("v%0d_req_valid", i), imem_req_valid, tbl[i].e_req);
            chk($sformatf("v%0d_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_instr_valid", i), instr_valid, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                chk($sformatf("v%0d_instr", i), instr, tbl[i].e_instr);
                chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
                chk($sformatf("v%0d_fetch_err", i), fetch_err, tbl[i].e_err);
            end
        end

        // Reset mid-fetch with a late response afterwards.
        idle(); imem_req_ready = 1'b1;
        @(negedge clk);
        chk("mid_wait_req", imem_req_valid, 1'b0);
        idle();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req", imem_req_valid, 1'b0);
        chk("mid_rst_iv", instr_valid, 1'b0);
        chk("mid_rst_addr", imem_req_addr, RPC);
        chk("mid_rst_err", fetch_err, 2'd0);
        @(negedge clk);
        rst = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0BAD;
        @(negedge clk);
        chk("late_rsp_req", imem_req_valid, 1'b1);
        chk("late_rsp_addr", imem_req_addr, RPC);
        chk("late_rsp_iv", instr_valid, 1'b0);
        @(negedge clk);
        chk("spurious_rsp_req", imem_req_valid, 1'b1);
        chk("spurious_rsp_iv", instr_valid, 1'b0);
        idle(); imem_req_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_hs", imem_req_valid, 1'b0);
        idle(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0055;
        @(negedge clk);
        chk("post_rst_iv", instr_valid, 1'b1);
        chk("post_rst_instr", instr, 32'h0000_0055);
        chk("post_rst_pc", pc, RPC);

        // Randomized run against the reference model.
        idle(); rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        mem_busy = 1'b0; mem_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            chk("rnd_req_valid", imem_req_valid, m_want);
            chk("rnd_addr", imem_req_addr, m_pc);
            chk("rnd_instr_valid", instr_valid, m_show);
            if (m_show) begin
                chk("rnd_instr", instr, m_instr);
                chk("rnd_pc", pc, m_pc);
                chk("rnd_fetch_err", fetch_err, m_err);
            end
            if (failures > 20) break;
            imem_req_ready = ($urandom_range(0, 3) != 0);
            imem_rsp_err = 1'b0;
            imem_rsp_data = $urandom;
            if (mem_busy) begin
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_err = ($urandom_range(0, 7) == 0);
                    mem_busy = 1'b0;
                end else begin
                    imem_rsp_valid = 1'b0;
                    mem_cnt--;
                end
            end else begin
                imem_rsp_valid = ($urandom_range(0, 19) == 0);
            end
            if (m_want && imem_req_ready) begin
                mem_busy = 1'b1;
                mem_cnt = $urandom_range(0, 2);
            end
            instr_ready = $urandom_range(0, 1);
            npc_valid = ($urandom_range(0, 2) == 0);
            npc = rand_pc();
            flush_valid = ($urandom_range(0, 24) == 0);
            flush_pc = rand_pc();
            m_step();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
